// File: rtl/sum_pkg.sv
// Widths, state encoding and shared types for the serial summer and its averaging stage.
package sum_pkg;

    localparam int unsigned SUM_W = 16;
    localparam int unsigned N_W   = 8;

    typedef enum logic [1:0] {IDLE, DIV, FIX, HOLD} avg_state_e;

    typedef logic signed [SUM_W-1:0] sum_t;
    typedef logic        [N_W-1:0]   n_t;

    // The most negative sum negates onto itself; read unsigned that is exactly 2^(SUM_W-1).
    function automatic logic [SUM_W-1:0] mag_of(input sum_t s);
        return s[SUM_W-1] ? SUM_W'(-s) : SUM_W'(s);
    endfunction

endpackage

// File: rtl/sum_avg_div_if.sv
// Block-sum input and averaged-result output bundle of the averaging stage.
interface sum_avg_div_if;
    import sum_pkg::*;

    logic en_i;
    logic done_i;
    sum_t sum_i;
    n_t   n_i;
    logic ready_i;

    sum_t avg_o;
    n_t   rem_o;
    logic dz_o;
    logic valid_o;
    logic busy_o;
    logic drop_o;

    modport slave (
        input  en_i, done_i, sum_i, n_i, ready_i,
        output avg_o, rem_o, dz_o, valid_o, busy_o, drop_o
    );

    modport master (
        output en_i, done_i, sum_i, n_i, ready_i,
        input  avg_o, rem_o, dz_o, valid_o, busy_o, drop_o
    );

endinterface

// File: rtl/serial_divider.sv
// Unsigned restoring divider: one quotient bit per clock, DW clocks after start.
module serial_divider
    import sum_pkg::*;
#(
    parameter int unsigned DW = SUM_W,
    parameter int unsigned VW = N_W
)
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [DW-1:0] dividend_i,
    input  logic [VW-1:0] divisor_i,
    output logic [DW-1:0] quot_o,
    output logic [VW-1:0] rem_o,
    output logic          done_o
);
    localparam int unsigned IW = $clog2(DW);

    logic          r_busy;
    logic [IW-1:0] r_iter;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_r;
    logic [VW-1:0] r_d;
    logic [VW:0]   w_trial;
    logic          w_ge;
    logic [VW-1:0] w_diff;

    // Partial remainder stays below the divisor, so the difference always fits VW bits.
    assign w_trial = {r_r, r_q[DW-1]};
    assign w_ge    = (w_trial >= {1'b0, r_d});
    assign w_diff  = w_trial[VW-1:0] - r_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= 1'b0;
            r_iter <= '0;
            r_q    <= '0;
            r_r    <= '0;
            r_d    <= '0;
        end else if (start_i) begin
            r_busy <= 1'b1;
            r_iter <= '0;
            r_q    <= dividend_i;
            r_r    <= '0;
            r_d    <= divisor_i;
        end else if (r_busy) begin
            r_q    <= {r_q[DW-2:0], w_ge};
            r_r    <= w_ge ? w_diff : w_trial[VW-1:0];
            r_iter <= r_iter + IW'(1);
            if (r_iter == IW'(DW-1)) r_busy <= 1'b0;
        end
    end

    assign quot_o = r_q;
    assign rem_o  = r_r;
    assign done_o = r_busy & (r_iter == IW'(DW-1));

endmodule

// File: rtl/sum_avg_div.sv
// Averaging stage: captures block sum/count, divides serially, holds signed result for the host.
// Define SUM_AVG_ROUND_EN to round half away from zero instead of truncating.
module sum_avg_div
    import sum_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    sum_avg_div_if.slave bus
);
    avg_state_e       r_state;
    logic             r_done_q;
    logic             r_sign;
    logic             r_zero;
    logic             r_valid;
    logic             r_drop;
    logic             r_dz;
    sum_t             r_avg;
    n_t               r_rem;

    logic             w_event;
    logic             w_accept;
    logic             w_start;
    logic             w_div_done;
    avg_state_e       w_cap_state;
    logic [SUM_W-1:0] w_quot;
    logic [SUM_W-1:0] w_mag;
    n_t               w_rem_u;
    n_t               w_rmag;
    sum_t             w_avg_fix;
    n_t               w_rem_fix;

    assign w_event     = bus.en_i & bus.done_i & ~r_done_q;
    assign w_accept    = w_event & ((r_state == IDLE) | ((r_state == HOLD) & bus.ready_i));
    assign w_start     = w_accept & (bus.n_i != '0);
    assign w_cap_state = (bus.n_i == '0) ? FIX : DIV;

    serial_divider #(.DW(SUM_W), .VW(N_W)) u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (w_start),
        .dividend_i (mag_of(bus.sum_i)),
        .divisor_i  (bus.n_i),
        .quot_o     (w_quot),
        .rem_o      (w_rem_u),
        .done_o     (w_div_done)
    );

`ifdef SUM_AVG_ROUND_EN
    n_t           r_n;
    logic         w_round;
    logic [SUM_W:0] w_q_rnd;
    logic [SUM_W:0] w_q_lim;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)       r_n <= '0;
        else if (w_accept) r_n <= bus.n_i;
    end

    always_comb begin
        w_round = ({w_rem_u, 1'b0} >= {1'b0, r_n});
        w_q_rnd = {1'b0, w_quot} + (SUM_W+1)'(w_round);
        w_q_lim = r_sign ? {2'b01, {(SUM_W-1){1'b0}}} : {2'b00, {(SUM_W-1){1'b1}}};
        w_mag   = (w_q_rnd > w_q_lim) ? w_q_lim[SUM_W-1:0] : w_q_rnd[SUM_W-1:0];
        w_rmag  = w_round ? (w_rem_u - r_n) : w_rem_u;
    end
`else
    assign w_mag  = w_quot;
    assign w_rmag = w_rem_u;
`endif

    assign w_avg_fix = r_sign ? sum_t'(-w_mag) : sum_t'(w_mag);
    assign w_rem_fix = r_sign ? n_t'(-w_rmag) : w_rmag;

    // A HOLD handshake and a fresh capture in the same cycle go straight back to work.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_done_q <= 1'b0;
            r_sign   <= 1'b0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
            r_dz     <= 1'b0;
            r_avg    <= '0;
            r_rem    <= '0;
        end else begin
            r_done_q <= bus.done_i;
            r_drop   <= w_event & ~w_accept;
            if (w_accept) begin
                r_sign <= bus.sum_i[SUM_W-1];
                r_zero <= (bus.n_i == '0);
            end
            case (r_state)
                IDLE: if (w_accept) r_state <= w_cap_state;
                DIV:  if (w_div_done) r_state <= FIX;
                FIX: begin
                    r_avg   <= r_zero ? '0 : w_avg_fix;
                    r_rem   <= r_zero ? '0 : w_rem_fix;
                    r_dz    <= r_zero;
                    r_valid <= 1'b1;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (bus.ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= w_accept ? w_cap_state : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.avg_o   = r_avg;
    assign bus.rem_o   = r_rem;
    assign bus.dz_o    = r_dz;
    assign bus.valid_o = r_valid;
    assign bus.busy_o  = (r_state != IDLE);
    assign bus.drop_o  = r_drop;

endmodule
